// File: rtl/y86_stage_sequencer_if.sv
// Handshake and datapath signals between the Y86 stage sequencer and its environment.
interface y86_stage_sequencer_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 32
);
  logic              start;
  logic [3:0]        icode;
  logic              instr_valid;
  logic              imem_error;
  logic              dmem_error;
  logic              mem_ack;
  logic              cnd;
  logic [ADDR_W-1:0] valC;
  logic [ADDR_W-1:0] valM;
  logic [ADDR_W-1:0] valP;
  logic [ADDR_W-1:0] pc;
  logic              fetch_en;
  logic              decode_en;
  logic              exec_en;
  logic              wb_en;
  logic              cc_we;
  logic              mem_req;
  logic [2:0]        stage;
  logic [2:0]        stat;
  logic              halted;
  logic [CNT_W-1:0]  retired;

  modport master (
    input  start, icode, instr_valid, imem_error, dmem_error, mem_ack, cnd, valC, valM, valP,
    output pc, fetch_en, decode_en, exec_en, wb_en, cc_we, mem_req, stage, stat, halted, retired
  );

  modport slave (
    output start, icode, instr_valid, imem_error, dmem_error, mem_ack, cnd, valC, valM, valP,
    input  pc, fetch_en, decode_en, exec_en, wb_en, cc_we, mem_req, stage, stat, halted, retired
  );
endinterface

// File: rtl/y86_stage_sequencer.sv
// Multi-cycle Y86 control sequencer: walks one instruction through fetch..PC update,
// tracks status, retired count and a bounded data-memory wait.
module y86_stage_sequencer #(
  parameter int unsigned       ADDR_W      = 64,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       CNT_W       = 32,
  parameter int unsigned       MEM_TIMEOUT = 15
) (
  input logic                  clk,
  input logic                  rst_n,
  y86_stage_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMemory    = 3'd4,
    StWriteback = 3'd5,
    StPcUpd     = 3'd6,
    StHalt      = 3'd7
  } state_e;

  localparam logic [2:0] StatAok  = 3'd1;
  localparam logic [2:0] StatHlt  = 3'd2;
  localparam logic [2:0] StatAdr  = 3'd3;
  localparam logic [2:0] StatIns  = 3'd4;
  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_pc, w_pc_d;
  logic [2:0]        r_stat, w_stat_d;
  logic [CNT_W-1:0]  r_retired, w_retired_d;
  logic [7:0]        r_wait, w_wait_d;
  logic [3:0]        r_icode, w_icode_d;
  logic              w_mem_op;

  assign w_mem_op = r_icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_pc      <= RESET_PC;
      r_stat    <= StatAok;
      r_retired <= '0;
      r_wait    <= '0;
      r_icode   <= '0;
    end else begin
      r_state   <= w_state_d;
      r_pc      <= w_pc_d;
      r_stat    <= w_stat_d;
      r_retired <= w_retired_d;
      r_wait    <= w_wait_d;
      r_icode   <= w_icode_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_pc_d      = r_pc;
    w_stat_d    = r_stat;
    w_retired_d = r_retired;
    w_wait_d    = r_wait;
    w_icode_d   = r_icode;
    unique case (r_state)
      StIdle: begin
        if (bus.start) w_state_d = StFetch;
      end
      StFetch: begin
        w_icode_d = bus.icode;
        if (bus.imem_error) begin
          w_stat_d  = StatAdr;
          w_state_d = StHalt;
        end else if (!bus.instr_valid) begin
          w_stat_d  = StatIns;
          w_state_d = StHalt;
        end else if (bus.icode == 4'h0) begin
          w_stat_d  = StatHlt;
          w_state_d = StHalt;
        end else begin
          w_state_d = StDecode;
        end
      end
      StDecode: w_state_d = StExecute;
      StExecute: begin
        w_wait_d  = '0;
        w_state_d = w_mem_op ? StMemory : StWriteback;
      end
      StMemory: begin
        // An ack arriving on the last allowed cycle still completes normally.
        if (bus.mem_ack) begin
          if (bus.dmem_error) begin
            w_stat_d  = StatAdr;
            w_state_d = StHalt;
          end else begin
            w_state_d = StWriteback;
          end
        end else if (r_wait == WaitLast) begin
          w_stat_d  = StatAdr;
          w_state_d = StHalt;
        end else begin
          w_wait_d = r_wait + 8'd1;
        end
      end
      StWriteback: w_state_d = StPcUpd;
      StPcUpd: begin
        if (r_icode == 4'h8 || (r_icode == 4'h7 && bus.cnd)) w_pc_d = bus.valC;
        else if (r_icode == 4'h9)                            w_pc_d = bus.valM;
        else                                                 w_pc_d = bus.valP;
        w_retired_d = r_retired + CNT_W'(1);
        w_state_d   = StFetch;
      end
      StHalt: w_state_d = StHalt;
    endcase
  end

  assign bus.pc        = r_pc;
  assign bus.stage     = r_state;
  assign bus.stat      = r_stat;
  assign bus.retired   = r_retired;
  assign bus.halted    = (r_state == StHalt);
  assign bus.fetch_en  = (r_state == StFetch);
  assign bus.decode_en = (r_state == StDecode);
  assign bus.exec_en   = (r_state == StExecute);
  assign bus.wb_en     = (r_state == StWriteback);
  assign bus.cc_we     = (r_state == StExecute) && (r_icode == 4'h6);
  assign bus.mem_req   = (r_state == StMemory);

endmodule

// File: tb/tb_y86_stage_sequencer.sv
// Scoreboard bench for y86_stage_sequencer: per-instruction expectations are queued at
// fetch and compared when the instruction retires or the sequencer halts.
module tb_y86_stage_sequencer;

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] valc, valm, valp;
    bit          cnd;
    int          dly;
    bit          derr, ierr, iv, stray, abort;
  } instr_t;

  typedef struct {
    int          id;
    logic [63:0] pc;
    logic [2:0]  stat;
    logic [31:0] ret;
    bit          halted;
    int          req_len;
    int          ccwe;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   ack_q = 1'b0;
  logic   stray = 1'b0;
  int     ack_delay = -1;
  int     req_cnt = 0;
  int     last_req_len = 0;
  int     ccwe_cnt = 0;
  int     onehot_err = 0;
  int     instr_id = 0;
  int     n_vec = 0;
  int     n_err = 0;
  logic [2:0] prev_stage = 3'd0;
  instr_t prog[$];
  exp_t   exp_q[$];

  y86_stage_sequencer_if #(.ADDR_W(64), .CNT_W(32)) bus ();

  y86_stage_sequencer #(
    .ADDR_W     (64),
    .RESET_PC   (64'h0),
    .CNT_W      (32),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  assign bus.mem_ack = ack_q | stray;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic instr_t mk(logic [3:0] ic, logic [63:0] c, logic [63:0] m, logic [63:0] p,
                                bit cn, int dly, bit derr, bit ierr, bit iv, bit str, bit ab);
    instr_t t;
    t.icode = ic; t.valc = c; t.valm = m; t.valp = p; t.cnd = cn; t.dly = dly;
    t.derr = derr; t.ierr = ierr; t.iv = iv; t.stray = str; t.abort = ab;
    return t;
  endfunction

  // Memory responder, strobe monitor and scoreboard compare share one process so that
  // the mem_req length is recorded before the retiring instruction is checked.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        req_cnt++;
        ack_q = (ack_delay >= 0) && (req_cnt == ack_delay + 1);
      end else begin
        if (req_cnt != 0) last_req_len = req_cnt;
        req_cnt = 0;
        ack_q   = 1'b0;
      end
      if (bus.cc_we) ccwe_cnt++;
      if (int'(bus.fetch_en) + int'(bus.decode_en) + int'(bus.exec_en) + int'(bus.wb_en) > 1)
        onehot_err++;
      if (!rst_n) begin
        prev_stage = 3'd0;
      end else begin
        if ((prev_stage == 3'd6 && bus.stage == 3'd1) ||
            (prev_stage != 3'd7 && bus.stage == 3'd7)) begin
          if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check_eq($sformatf("i%0d_pc", e.id), bus.pc, e.pc);
            check_eq($sformatf("i%0d_stat", e.id), bus.stat, e.stat);
            check_eq($sformatf("i%0d_retired", e.id), bus.retired, e.ret);
            check_eq($sformatf("i%0d_halted", e.id), bus.halted, e.halted);
            check_eq($sformatf("i%0d_req_len", e.id), last_req_len, e.req_len);
            check_eq($sformatf("i%0d_cc_we", e.id), ccwe_cnt, e.ccwe);
          end
          last_req_len = 0;
          ccwe_cnt     = 0;
        end
        prev_stage = bus.stage;
      end
    end
  end

  task automatic wait_stage(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (bus.stage == s) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic reset_checks(input string pfx);
    check_eq({pfx, "_stage"}, bus.stage, 3'd0);
    check_eq({pfx, "_pc"}, bus.pc, 64'h0);
    check_eq({pfx, "_stat"}, bus.stat, 3'd1);
    check_eq({pfx, "_retired"}, bus.retired, 32'd0);
    check_eq({pfx, "_halted"}, bus.halted, 1'b0);
    check_eq({pfx, "_strobes"}, {bus.fetch_en, bus.decode_en, bus.exec_en, bus.wb_en,
                                 bus.cc_we, bus.mem_req}, 6'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.icode = 4'h0; bus.instr_valid = 1'b1; bus.imem_error = 1'b0;
    bus.dmem_error = 1'b0; bus.cnd = 1'b0; bus.valC = '0; bus.valM = '0; bus.valP = '0;
    stray = 1'b0; ack_delay = -1;
    #1;
    reset_checks("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_req_len = 0;
    ccwe_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_prog(input bit chk_strobes);
    instr_t      p;
    exp_t        e;
    bit          ok;
    bit          is_mem;
    logic [63:0] m_pc;
    logic [31:0] m_ret;
    logic [5:0]  strb_exp [5];
    strb_exp[0] = 6'b100000; strb_exp[1] = 6'b010000; strb_exp[2] = 6'b001010;
    strb_exp[3] = 6'b000100; strb_exp[4] = 6'b000000;
    do_reset();
    m_pc = 64'h0;
    m_ret = 32'd0;
    pulse_start();
    foreach (prog[i]) begin
      p = prog[i];
      wait_stage(3'd1, 60, ok);
      if (!ok) begin
        check_eq("fetch_wait", bus.stage, 3'd1);
        break;
      end
      check_eq($sformatf("i%0d_fetch_pc", instr_id), bus.pc, m_pc);
      bus.icode = p.icode; bus.valC = p.valc; bus.valM = p.valm; bus.valP = p.valp;
      bus.cnd = p.cnd; bus.instr_valid = p.iv; bus.imem_error = p.ierr;
      bus.dmem_error = p.derr; stray = p.stray; ack_delay = p.dly;
      if (p.abort) begin
        @(negedge clk);
        bus.icode = p.icode ^ 4'h3;
        wait_stage(3'd4, 10, ok);
        check_eq("abort_in_mem", bus.stage, 3'd4);
        repeat (3) @(negedge clk);
        check_eq("abort_req", bus.mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("abort");
        @(negedge clk);
        rst_n = 1'b1;
        ack_delay = -1;
        m_pc = 64'h0;
        m_ret = 32'd0;
        pulse_start();
        last_req_len = 0;
        ccwe_cnt = 0;
        instr_id++;
        continue;
      end
      e.id = instr_id; e.stat = 3'd1; e.halted = 1'b0; e.req_len = 0; e.ccwe = 0;
      if (p.ierr) begin
        e.stat = 3'd3; e.halted = 1'b1;
      end else if (!p.iv) begin
        e.stat = 3'd4; e.halted = 1'b1;
      end else if (p.icode == 4'h0) begin
        e.stat = 3'd2; e.halted = 1'b1;
      end else begin
        is_mem = p.icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        if (p.icode == 4'h6) e.ccwe = 1;
        if (is_mem) begin
          if (p.dly < 0 || p.dly >= 15) begin
            e.req_len = 15; e.stat = 3'd3; e.halted = 1'b1;
          end else begin
            e.req_len = p.dly + 1;
            if (p.derr) begin
              e.stat = 3'd3; e.halted = 1'b1;
            end
          end
        end
        if (!e.halted) begin
          if (p.icode == 4'h8 || (p.icode == 4'h7 && p.cnd)) m_pc = p.valc;
          else if (p.icode == 4'h9)                          m_pc = p.valm;
          else                                               m_pc = p.valp;
          m_ret = m_ret + 32'd1;
        end
      end
      e.pc = m_pc;
      e.ret = m_ret;
      exp_q.push_back(e);
      if (chk_strobes && i == 0)
        check_eq("strobe_c0", {bus.fetch_en, bus.decode_en, bus.exec_en, bus.wb_en,
                               bus.cc_we, bus.mem_req}, strb_exp[0]);
      @(negedge clk);
      bus.icode = p.icode ^ 4'h3;
      if (chk_strobes && i == 0) begin
        for (int c = 1; c < 5; c++) begin
          if (c > 1) @(negedge clk);
          check_eq($sformatf("strobe_c%0d", c), {bus.fetch_en, bus.decode_en, bus.exec_en,
                                                 bus.wb_en, bus.cc_we, bus.mem_req},
                   strb_exp[c]);
        end
      end
      instr_id++;
      if (e.halted) break;
    end
    wait_stage(3'd7, 60, ok);
    check_eq("final_halt", bus.stage, 3'd7);
    @(negedge clk);
    check_eq("sb_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.icode = 4'h0; bus.instr_valid = 1'b1; bus.imem_error = 1'b0;
    bus.dmem_error = 1'b0; bus.cnd = 1'b0; bus.valC = '0; bus.valM = '0; bus.valP = '0;

    // OPq then halt; strobe order, then start while halted
    prog.delete();
    prog.push_back(mk(4'h6, 64'h0, 64'h0, 64'h0A, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    prog.push_back(mk(4'h0, 64'h0, 64'h0, 64'h99, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    run_prog(1'b1);
    pulse_start();
    repeat (3) @(negedge clk);
    check_eq("halt_start_stage", bus.stage, 3'd7);
    check_eq("halt_start_pc", bus.pc, 64'h0A);
    check_eq("halt_start_retired", bus.retired, 32'd1);
    check_eq("halt_start_stat", bus.stat, 3'd2);

    // Jumps, stray ack, call/ret, ack at the timeout limit, dmem error
    prog.delete();
    prog.push_back(mk(4'h7, 64'h40, 64'h0, 64'h09, 1'b1, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    prog.push_back(mk(4'h7, 64'h40, 64'h0, 64'h09, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    prog.push_back(mk(4'h6, 64'h0, 64'h0, 64'h77, 1'b0, -1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
    prog.push_back(mk(4'h2, 64'h0, 64'h0, 64'h30, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    prog.push_back(mk(4'h8, 64'h200, 64'h0, 64'h3A, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    prog.push_back(mk(4'h9, 64'h0, 64'h100, 64'h201, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    prog.push_back(mk(4'h5, 64'h0, 64'h0, 64'h123, 1'b0, 14, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    prog.push_back(mk(4'h4, 64'h0, 64'h0, 64'h555, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    run_prog(1'b0);

    // Memory timeout
    prog.delete();
    prog.push_back(mk(4'h5, 64'h0, 64'h0, 64'h55, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    run_prog(1'b0);

    // Fetch faults
    prog.delete();
    prog.push_back(mk(4'h6, 64'h0, 64'h0, 64'h11, 1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    run_prog(1'b0);
    prog.delete();
    prog.push_back(mk(4'h6, 64'h0, 64'h0, 64'h11, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    run_prog(1'b0);

    // Asynchronous reset while waiting in MEMORY, then restart from RESET_PC
    prog.delete();
    prog.push_back(mk(4'h8, 64'h40, 64'h0, 64'h0A, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    prog.push_back(mk(4'h5, 64'h0, 64'h0, 64'h66, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    prog.push_back(mk(4'h6, 64'h0, 64'h0, 64'h22, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    prog.push_back(mk(4'h0, 64'h0, 64'h0, 64'h99, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    run_prog(1'b0);

    check_eq("strobe_onehot", onehot_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
